// File: rtl/data_mem_responder.sv
// data_mem_responder
//
// Responder end of the MEM-stage load/store interface. One word request is
// accepted over req_valid/req_ready, held for a fixed number of wait states,
// then answered over rsp_valid/rsp_ready. Stores apply per-byte strobes;
// misaligned or out-of-range requests are answered with rsp_err=1 and never
// touch the array.
//
// Handshake rule (both channels): a transfer happens on a rising edge where
// valid and ready are both 1. The sender holds valid and its payload stable
// until that edge. The responder samples req_* only on the accept edge and
// holds rsp_* stable while rsp_valid=1 and rsp_ready=0.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   request handshake (ready is high only in IDLE)
//   req_write             1 = store, 0 = load
//   req_addr              byte address
//   req_wdata/req_wstrb   store data and byte enables (byte i = bits 8i+7:8i)
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             load data (0 for stores and errored requests)
//   rsp_err               misaligned or out-of-range request
//
// The FSM state is held in `state` (type state_t) for checkers to bind to.

module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;

  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_wstrb;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] word_idx;
  logic          err_misalign;
  logic          err_range;
  logic          req_err;
  logic          accept;
  logic          commit;

  assign word_idx     = lat_addr[AW+1:2];
  assign err_misalign = (lat_addr[1:0] != 2'b00);
  assign err_range    = (lat_addr[31:AW+2] != '0);
  assign req_err      = err_misalign | err_range;

  assign accept = (state == S_IDLE) && req_valid;
  // The edge that leaves WAIT enters RESP: this is the single array access.
  // WAIT is visited even for LATENCY=1, so rsp_valid always rises exactly
  // LATENCY edges after the accept edge.
  assign commit = (state == S_WAIT) && (cnt == 4'd0);

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= 4'(LATENCY - 1);
      end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        rsp_err   <= req_err;
        rsp_rdata <= (!lat_write && !req_err) ? mem[word_idx] : 32'd0;
      end else if ((state == S_RESP) && rsp_ready) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= 32'd0;
      end
    end
  end

  // Request payload is captured only on the accept edge; later input
  // changes are ignored until the next IDLE.
  always_ff @(posedge clk) begin
    if (accept && rst_n) begin
      lat_write <= req_write;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_wstrb <= req_wstrb;
    end
  end

  // Array is not reset. A reset edge suppresses a pending commit, so a store
  // abandoned in WAIT never lands.
  always_ff @(posedge clk) begin
    if (rst_n && commit && lat_write && !req_err) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_wstrb[i]) mem[word_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic        clk;
  logic        rst_n     [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_write [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_wstrb [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference memory per instance, 256 words each.
  logic [31:0] model [3][256];
  logic [31:0] exp_q [$];

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_wstrb(req_wstrb[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_wstrb(req_wstrb[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(15)) u_l15 (
    .clk(clk), .rst_n(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .req_wstrb(req_wstrb[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

  function automatic int lat_of(input int d);
    case (d)
      0: return 2;
      1: return 1;
      default: return 15;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (st[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // Reference model: a request is legal only if word aligned and inside the
  // 1 KiB array; legal stores merge bytes, legal loads return the word.
  task automatic model_op(input int d, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] st,
                          output logic [31:0] er, output logic ee);
    int idx;
    ee = (addr % 4 != 0) || (addr >= 32'd1024);
    er = 32'd0;
    if (!ee) begin
      idx = int'(addr / 4);
      if (wr) model[d][idx] = merge(model[d][idx], wd, st);
      else    er = model[d][idx];
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input int d, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] st);
    int n;
    n = 0;
    while (!req_ready[d] && n < 100) begin
      tick();
      n++;
    end
    if (!req_ready[d]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout inst %0d: req_ready=%0b required 1", d, req_ready[d]);
    end
    req_write[d] = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wd;
    req_wstrb[d] = st;
    req_valid[d] = 1'b1;
    tick();
    req_valid[d] = 1'b0;
    // Scramble the payload after acceptance; the responder must ignore it.
    req_write[d] = $urandom_range(0, 1);
    req_addr[d]  = $urandom;
    req_wdata[d] = $urandom;
    req_wstrb[d] = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_rsp(input int d, output int lat);
    lat = 0;
    while (!rsp_valid[d] && lat < 64) begin
      tick();
      lat++;
    end
    if (!rsp_valid[d]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rsp_timeout inst %0d: rsp_valid=0 required 1", d);
    end
  endtask

  task automatic complete_rsp(input int d);
    rsp_ready[d] = 1'b1;
    tick();
    rsp_ready[d] = 1'b0;
  endtask

  task automatic do_req(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rd, output logic er, output int lat);
    send_req(d, wr, addr, wd, st);
    wait_rsp(d, lat);
    rd = rsp_rdata[d];
    er = rsp_err[d];
    complete_rsp(d);
  endtask

  // scenarios
  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0;
      tick();
      tick();
      n_cmp++;
      if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 ||
          rsp_rdata[d] !== 32'd0 || rsp_err[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset inst %0d: rdy=%0b vld=%0b rdata=%h err=%0b required 1 0 0 0",
                 d, req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_err[d]);
      end
      rst_n[d] = 1'b1;
    end
    tick();
  endtask

  task automatic init_mem();
    logic [31:0] rd, er_d;
    logic er;
    int lat;
    for (int d = 0; d < 3; d++) begin
      for (int w = 0; w < 16; w++) begin
        er_d = $urandom;
        model_op(d, 1'b1, 32'(w * 4), er_d, 4'hF, rd, er);
        do_req(d, 1'b1, 32'(w * 4), er_d, 4'hF, rd, er, lat);
        n_cmp++;
        if (er !== 1'b0 || lat != lat_of(d)) begin
          n_bad++;
          $display("FAIL init inst %0d word %0d: err=%0b lat=%0d required 0 %0d",
                   d, w, er, lat, lat_of(d));
        end
      end
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd, mr;
    logic er, me;
    int lat;
    model_op(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, mr, me);
    send_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    wait_rsp(0, lat);
    n_cmp++;
    if (lat != 2 || rsp_err[0] !== 1'b0 || rsp_rdata[0] !== 32'd0) begin
      n_bad++;
      $display("FAIL store_rsp: lat=%0d err=%0b rdata=%h required 2 0 00000000",
               lat, rsp_err[0], rsp_rdata[0]);
    end
    complete_rsp(0);
    n_cmp++;
    if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL after_handshake: vld=%0b rdy=%0b required 0 1", rsp_valid[0], req_ready[0]);
    end
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    n_cmp++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat != 2) begin
      n_bad++;
      $display("FAIL load_after_store: rdata=%h err=%0b lat=%0d required deadbeef 0 2", rd, er, lat);
    end
  endtask

  task automatic test_byte_strobes();
    logic [31:0] rd, mr;
    logic er, me;
    int lat;
    model_op(0, 1'b1, 32'h20, 32'h11223344, 4'hF, mr, me);
    do_req(0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
    model_op(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, mr, me);
    do_req(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat);
    do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    n_cmp++;
    if (rd !== 32'h11BB33DD || er !== 1'b0) begin
      n_bad++;
      $display("FAIL byte_strobe: rdata=%h err=%0b required 11bb33dd 0", rd, er);
    end
    // Zero strobes: legal store, no change.
    model_op(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, mr, me);
    do_req(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rd, er, lat);
    n_cmp++;
    if (er !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_strobe_err: err=%0b required 0", er);
    end
    do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    n_cmp++;
    if (rd !== 32'h11BB33DD) begin
      n_bad++;
      $display("FAIL zero_strobe_data: rdata=%h required 11bb33dd", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, mr;
    logic er, me;
    int lat;
    do_req(0, 1'b0, 32'h13, 32'h0, 4'h0, rd, er, lat);
    n_cmp++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      n_bad++;
      $display("FAIL misalign_load: err=%0b rdata=%h required 1 00000000", er, rd);
    end
    do_req(0, 1'b1, 32'h400, 32'hCAFEF00D, 4'hF, rd, er, lat);
    n_cmp++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      n_bad++;
      $display("FAIL range_store: err=%0b rdata=%h required 1 00000000", er, rd);
    end
    model_op(0, 1'b0, 32'h0, 32'h0, 4'h0, mr, me);
    do_req(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    n_cmp++;
    if (rd !== mr || er !== 1'b0) begin
      n_bad++;
      $display("FAIL range_no_alias: rdata=%h err=%0b required %h 0", rd, er, mr);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] mr;
    logic me;
    int lat;
    model_op(0, 1'b0, 32'h10, 32'h0, 4'h0, mr, me);
    send_req(0, 1'b0, 32'h10, 32'h0, 4'h0);
    wait_rsp(0, lat);
    for (int c = 0; c < 5; c++) begin
      req_valid[0] = c[0];
      req_write[0] = 1'b1;
      req_addr[0]  = 32'h10;
      req_wdata[0] = 32'h0BADF00D;
      req_wstrb[0] = 4'hF;
      tick();
      n_cmp++;
      if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== mr || rsp_err[0] !== 1'b0 ||
          req_ready[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL backpressure cyc %0d: vld=%0b rdata=%h err=%0b rdy=%0b required 1 %h 0 0",
                 c, rsp_valid[0], rsp_rdata[0], rsp_err[0], req_ready[0], mr);
      end
    end
    req_valid[0] = 1'b0;
    complete_rsp(0);
    n_cmp++;
    if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release: rdy=%0b vld=%0b required 1 0", req_ready[0], rsp_valid[0]);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++;
      if (rsp_valid[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_ghost cyc %0d: vld=%0b required 0", c, rsp_valid[0]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, mr, addr, wd;
    logic er, me;
    logic [3:0] st;
    bit wr;
    int lat, d, k;
    for (int n = 0; n < 40; n++) begin
      d  = $urandom_range(0, 2);
      k  = $urandom_range(0, 9);
      wr = $urandom_range(0, 1);
      wd = $urandom;
      st = 4'($urandom_range(0, 15));
      if (k < 8)       addr = 32'($urandom_range(0, 15) * 4);
      else if (k == 8) addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else             addr = {$urandom_range(1, 32'h3FFFFF), 8'h0} & 32'hFFFFFFFC;
      model_op(d, wr, addr, wd, st, mr, me);
      do_req(d, wr, addr, wd, st, rd, er, lat);
      n_cmp++;
      if (rd !== mr || er !== me || lat != lat_of(d)) begin
        n_bad++;
        $display("FAIL random %0d inst %0d wr=%0b addr=%h: rdata=%h err=%0b lat=%0d required %h %0b %0d",
                 n, d, wr, addr, rd, er, lat, mr, me, lat_of(d));
      end
    end
  endtask

  task automatic test_back_to_back(input int d);
    int cyc, acc_cyc, got, idx;
    bit pre_acc, pre_hs, prev_v;
    logic [31:0] e;
    exp_q.delete();
    cyc = 0;
    acc_cyc = -1000;
    got = 0;
    prev_v = rsp_valid[d];
    req_write[d] = 1'b0;
    req_addr[d]  = 32'($urandom_range(0, 15) * 4);
    req_valid[d] = 1'b1;
    rsp_ready[d] = 1'b1;
    while (got < 6 && cyc < 500) begin
      pre_acc = req_valid[d] && req_ready[d];
      pre_hs  = rsp_valid[d] && rsp_ready[d];
      tick();
      cyc++;
      if (pre_acc) begin
        acc_cyc = cyc;
        idx = int'(req_addr[d] / 4);
        exp_q.push_back(model[d][idx]);
        req_addr[d] = 32'($urandom_range(0, 15) * 4);
      end
      if (pre_hs) begin
        n_cmp++;
        if (req_ready[d] !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_ready inst %0d cyc %0d: rdy=%0b required 1", d, cyc, req_ready[d]);
        end
      end
      if (rsp_valid[d] && !prev_v) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hX;
        n_cmp++;
        if (cyc - acc_cyc != lat_of(d) || rsp_rdata[d] !== e || rsp_err[d] !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_rsp inst %0d: lat=%0d rdata=%h err=%0b required %0d %h 0",
                   d, cyc - acc_cyc, rsp_rdata[d], rsp_err[d], lat_of(d), e);
        end
        got++;
      end
      prev_v = rsp_valid[d];
    end
    req_valid[d] = 1'b0;
    if (got < 6) begin
      n_cmp++;
      n_bad++;
      $display("FAIL b2b_timeout inst %0d: responses=%0d required 6", d, got);
    end
    tick();
    rsp_ready[d] = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd, mr;
    logic er, me;
    int lat;
    model_op(0, 1'b1, 32'h08, 32'h12345678, 4'hF, mr, me);
    do_req(0, 1'b1, 32'h08, 32'h12345678, 4'hF, rd, er, lat);
    send_req(0, 1'b1, 32'h08, 32'h55555555, 4'hF);
    rst_n[0] = 1'b0;
    tick();
    n_cmp++;
    if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0 ||
        rsp_rdata[0] !== 32'd0 || rsp_err[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_wait_reset: rdy=%0b vld=%0b rdata=%h err=%0b required 1 0 0 0",
               req_ready[0], rsp_valid[0], rsp_rdata[0], rsp_err[0]);
    end
    rst_n[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++;
      if (rsp_valid[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL mid_wait_no_rsp cyc %0d: vld=%0b required 0", c, rsp_valid[0]);
      end
    end
    model_op(0, 1'b0, 32'h08, 32'h0, 4'h0, mr, me);
    do_req(0, 1'b0, 32'h08, 32'h0, 4'h0, rd, er, lat);
    n_cmp++;
    if (rd !== 32'h12345678 || rd !== mr) begin
      n_bad++;
      $display("FAIL mid_wait_not_committed: rdata=%h required 12345678", rd);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_n[d]     = 1'b0;
      req_valid[d] = 1'b0;
      req_write[d] = 1'b0;
      req_addr[d]  = 32'd0;
      req_wdata[d] = 32'd0;
      req_wstrb[d] = 4'd0;
      rsp_ready[d] = 1'b0;
    end
    tick();
    test_reset();
    init_mem();
    test_store_load();
    test_byte_strobes();
    test_errors();
    test_backpressure();
    test_back_to_back(1);
    test_back_to_back(2);
    test_back_to_back(0);
    test_random();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
